// File: rtl/seq_pattern_tx_pkg.sv
// seq_tx_pkg: shared types and defaults for the serial pattern transmitter.
//   state_e     : transmitter FSM states (IDLE, SEND, GAP, DONE)
//   DEF_PATTERN : pattern held in the shift register out of reset (1111001)
//   DEF_*_W     : default pattern / repeat-counter / gap-counter widths
package seq_tx_pkg;

  localparam int DEF_PAT_W = 7;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP_W = 4;

  localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 7'b1111001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// seq_pattern_tx_if: control and serial-output bundle of the pattern transmitter.
//   start, cfg_pattern, cfg_repeat, cfg_gap, err_inj : requester -> transmitter
//   x_out, x_valid, busy, done                       : transmitter -> requester
// Handshake: start is a request that is accepted only on a clock edge where
// the transmitter is IDLE (busy=0); it is not queued, so a start seen while
// busy is dropped. x_valid qualifies x_out on every cycle (no back-pressure);
// done is a single-cycle completion pulse.
// Modports: master = requester/bench side, slave = transmitter side.
interface seq_pattern_tx_if #(
  parameter int PAT_W = seq_tx_pkg::DEF_PAT_W,
  parameter int CNT_W = seq_tx_pkg::DEF_CNT_W,
  parameter int GAP_W = seq_tx_pkg::DEF_GAP_W
);

  logic             start;
  logic [PAT_W-1:0] cfg_pattern;
  logic [CNT_W-1:0] cfg_repeat;
  logic [GAP_W-1:0] cfg_gap;
  logic             err_inj;
  logic             x_out;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, cfg_pattern, cfg_repeat, cfg_gap, err_inj,
    input  x_out, x_valid, busy, done
  );

  modport slave (
    input  start, cfg_pattern, cfg_repeat, cfg_gap, err_inj,
    output x_out, x_valid, busy, done
  );

endinterface

// File: rtl/seq_pattern_tx_shreg.sv
// seq_piso_shreg: parallel-load, shift-left register with MSB serial output.
//   clk, rst   : clock, asynchronous active-high reset (to RST_VAL)
//   load_i     : load din_i (takes priority over shift_i)
//   shift_i    : shift left by one, zero fill
//   din_i      : parallel load data
//   msb_o      : current MSB (next serial bit)
module seq_piso_shreg #(
  parameter int               PAT_W   = seq_tx_pkg::DEF_PAT_W,
  parameter logic [PAT_W-1:0] RST_VAL = seq_tx_pkg::DEF_PATTERN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] din_i,
  output logic             msb_o
);

  logic [PAT_W-1:0] sh_q;
  logic [PAT_W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (load_i)       sh_d = din_i;
    else if (shift_i) sh_d = sh_q << 1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sh_q <= RST_VAL;
    else     sh_q <= sh_d;
  end

  assign msb_o = sh_q[PAT_W-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: bit-serial pattern transmitter. On an accepted start it
// sends the latched PAT_W-bit pattern MSB-first, cfg_repeat+1 times, with
// cfg_gap idle cycles between frames, then pulses done.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : seq_pattern_tx_if.slave (start/cfg_*/err_inj in; x_out/x_valid/busy/done out)
//   state_o  : current FSM state, for debug/checkers
// Build option: SEQ_PATTERN_TX_ERR_INJ_EN -- when defined, err_inj sampled with
// start inverts the last bit of the first frame only.
module seq_pattern_tx #(
  parameter int               PAT_W       = seq_tx_pkg::DEF_PAT_W,
  parameter logic [PAT_W-1:0] DEF_PATTERN = seq_tx_pkg::DEF_PATTERN,
  parameter int               CNT_W       = seq_tx_pkg::DEF_CNT_W,
  parameter int               GAP_W       = seq_tx_pkg::DEF_GAP_W
) (
  input  logic                clk,
  input  logic                rst,
  seq_pattern_tx_if.slave     bus,
  output seq_tx_pkg::state_e  state_o
);

  import seq_tx_pkg::*;

  localparam int               BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

  state_e           state_q,   state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] rem_q,     rem_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [PAT_W-1:0] pat_q,     pat_d;

  logic             sh_load;
  logic             sh_shift;
  logic [PAT_W-1:0] sh_din;
  logic             sh_msb;
  logic [PAT_W-1:0] inj_mask;

  // Error injection is folded into the first load only; reloads for later
  // frames come from pat_q, which always holds the clean pattern.
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
  assign inj_mask = {{(PAT_W-1){1'b0}}, bus.err_inj};
`else
  logic unused_err_inj;
  assign unused_err_inj = bus.err_inj;
  assign inj_mask       = '0;
`endif

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rem_d     = rem_q;
    gap_cnt_d = gap_cnt_q;
    gap_d     = gap_q;
    pat_d     = pat_q;
    sh_load   = 1'b0;
    sh_shift  = 1'b0;
    sh_din    = pat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          pat_d     = bus.cfg_pattern;
          rem_d     = bus.cfg_repeat;
          gap_d     = bus.cfg_gap;
          bit_cnt_d = '0;
          sh_load   = 1'b1;
          sh_din    = bus.cfg_pattern ^ inj_mask;
          state_d   = SEND;
        end
      end
      SEND: begin
        sh_shift  = 1'b1;
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          if (rem_q == '0) begin
            state_d = DONE;
          end else if (gap_q == '0) begin
            // Back-to-back: reload on the last bit so the next frame's MSB
            // follows with no bubble.
            sh_load = 1'b1;
            rem_d   = rem_q - 1'b1;
          end else begin
            gap_cnt_d = '0;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q + 1'b1;
        if (gap_cnt_q == gap_q - GAP_W'(1)) begin
          sh_load = 1'b1;
          rem_d   = rem_q - 1'b1;
          state_d = SEND;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rem_q     <= '0;
      gap_cnt_q <= '0;
      gap_q     <= '0;
      pat_q     <= DEF_PATTERN;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rem_q     <= rem_d;
      gap_cnt_q <= gap_cnt_d;
      gap_q     <= gap_d;
      pat_q     <= pat_d;
    end
  end

  seq_piso_shreg #(
    .PAT_W   (PAT_W),
    .RST_VAL (DEF_PATTERN)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sh_load),
    .shift_i (sh_shift),
    .din_i   (sh_din),
    .msb_o   (sh_msb)
  );

  // Outputs decode registered state only, so reset clears them at once.
  assign bus.x_valid = (state_q == SEND);
  assign bus.x_out   = (state_q == SEND) & sh_msb;
  assign bus.busy    = (state_q != IDLE);
  assign bus.done    = (state_q == DONE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed bench for seq_pattern_tx with hand-computed
// expected bit streams, busy lengths and done positions.
module tb_seq_pattern_tx;

  import seq_tx_pkg::*;

  logic   clk;
  logic   rst;
  state_e state_o;
  int     chk_cnt  = 0;
  int     pass_cnt = 0;

  seq_pattern_tx_if bus ();

  seq_pattern_tx dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .state_o (state_o)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    chk_cnt++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else             pass_cnt++;
  endtask

  // ---------------- driver + collector ----------------
  // Issues one start, then walks the busy window cycle by cycle. Cycle 1 is
  // the first cycle after the accepting edge.
  task automatic run_case(input string tag, input logic [6:0] pat, input logic [3:0] rep,
                          input logic [3:0] gap, input logic err, input logic [127:0] exp_bits,
                          input int exp_n, input int exp_busy, input bit mid_start);
    logic [127:0] bits;
    int n, busy_n, done_n, done_cyc, cyc;
    bits = '0; n = 0; busy_n = 0; done_n = 0; done_cyc = -1;
    bus.start = 1'b1; bus.cfg_pattern = pat; bus.cfg_repeat = rep;
    bus.cfg_gap = gap; bus.err_inj = err;
    tick();
    bus.start = 1'b0; bus.err_inj = 1'b0;
    cyc = 1;
    while (bus.busy && cyc < 400) begin
      busy_n++;
      if (bus.x_valid) begin
        bits = {bits[126:0], bus.x_out};
        n++;
      end else begin
        check({tag, "_xout_idle"}, 128'(bus.x_out), 128'(1'b0));
      end
      if (bus.done) begin
        done_n++;
        done_cyc = cyc;
      end
      if (mid_start && cyc == 4) begin
        bus.start = 1'b1; bus.cfg_pattern = 7'b0100110;
        bus.cfg_repeat = 4'd3; bus.cfg_gap = 4'd5;
      end
      if (mid_start && cyc == 5) bus.start = 1'b0;
      tick();
      cyc++;
    end
    check({tag, "_terminated"}, 128'(cyc < 400), 128'(1));
    check({tag, "_nbits"},      128'(n),         128'(exp_n));
    check({tag, "_bits"},       bits,            exp_bits);
    check({tag, "_busy_cycles"},128'(busy_n),    128'(exp_busy));
    check({tag, "_done_count"}, 128'(done_n),    128'(1));
    check({tag, "_done_cycle"}, 128'(done_cyc),  128'(exp_busy));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] exp_err;
    bit seen;
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_pattern = '0; bus.cfg_repeat = '0;
    bus.cfg_gap = '0; bus.err_inj = 1'b0;
    #2;
    check("rst_x_out",   128'(bus.x_out),   128'(0));
    check("rst_x_valid", 128'(bus.x_valid), 128'(0));
    check("rst_busy",    128'(bus.busy),    128'(0));
    check("rst_done",    128'(bus.done),    128'(0));
    check("rst_state",   128'(state_o),     128'(IDLE));
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // single frame
    run_case("single", 7'b1111001, 4'd0, 4'd0, 1'b0, 128'b1111001, 7, 8, 1'b0);
    // three frames, 3-cycle gaps: 3*7 + 2*3 + 1 = 28
    run_case("gap3", 7'b1111001, 4'd2, 4'd3, 1'b0, 128'b111100111110011111001, 21, 28, 1'b0);
    // back-to-back
    run_case("b2b", 7'b1111001, 4'd1, 4'd0, 1'b0, 128'b11110011111001, 14, 15, 1'b0);
    // single-cycle gap: 14 + 1 + 1 = 16
    run_case("gap1", 7'b0000001, 4'd1, 4'd1, 1'b0, 128'b00000010000001, 14, 16, 1'b0);
    // start and cfg changes while busy are ignored
    run_case("busy_start", 7'b1011011, 4'd0, 4'd0, 1'b0, 128'b1011011, 7, 8, 1'b1);
    // max repeat and gap: 16*7 + 15*15 + 1 = 338
    run_case("max", 7'b1100101, 4'd15, 4'd15, 1'b0, {16{7'b1100101}}, 112, 338, 1'b0);

    // error inject: last bit of frame 1 inverted only when the option is built
`ifdef SEQ_PATTERN_TX_ERR_INJ_EN
    exp_err = 128'b11110001111001;
`else
    exp_err = 128'b11110011111001;
`endif
    run_case("err_inj", 7'b1111001, 4'd1, 4'd2, 1'b1, exp_err, 14, 17, 1'b0);

    // start held high: re-accepted in the IDLE cycle after DONE
    bus.start = 1'b1; bus.cfg_pattern = 7'b1111001; bus.cfg_repeat = '0; bus.cfg_gap = '0;
    tick();
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (bus.done) seen = 1'b1;
      else          tick();
    end
    check("hold_done_seen", 128'(seen), 128'(1));
    tick();
    check("hold_idle_busy",    128'(bus.busy),    128'(0));
    check("hold_idle_x_valid", 128'(bus.x_valid), 128'(0));
    tick();
    check("hold_restart_busy",  128'(bus.busy),    128'(1));
    check("hold_restart_valid", 128'(bus.x_valid), 128'(1));
    check("hold_restart_msb",   128'(bus.x_out),   128'(1));
    bus.start = 1'b0;
    for (int k = 0; k < 20 && bus.busy; k++) tick();
    check("hold_back_idle", 128'(bus.busy), 128'(0));

    // reset mid-frame at bit 3
    bus.start = 1'b1; bus.cfg_pattern = 7'b1111001; bus.cfg_repeat = 4'd2; bus.cfg_gap = 4'd1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("midrst_pre_valid", 128'(bus.x_valid), 128'(1));
    #2 rst = 1'b1;
    #1;
    check("midrst_x_out",   128'(bus.x_out),   128'(0));
    check("midrst_x_valid", 128'(bus.x_valid), 128'(0));
    check("midrst_busy",    128'(bus.busy),    128'(0));
    check("midrst_done",    128'(bus.done),    128'(0));
    check("midrst_state",   128'(state_o),     128'(IDLE));
    @(posedge clk);
    #3 rst = 1'b0;
    tick();
    check("midrst_stays_idle", 128'(bus.busy), 128'(0));
    check("midrst_no_done",    128'(bus.done), 128'(0));
    run_case("after_rst", 7'b1010011, 4'd0, 4'd0, 1'b0, 128'b1010011, 7, 8, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
